sky_shader_pipe: RTL and testbench
==================================

Name: sky_shader_pipe

Overview:
Pipelined, parametrised successor to the combinational sky-colour function. Accepts one ray direction per cycle with a tag and returns a saturated 24-bit {B,G,R} sky colour.
- Sky gradient endpoints, sun tint and light direction are runtime-configurable; sun sharpness is a compile-time choice.
- Sits between the ray-miss path of the tracer and the framebuffer writer, with valid/ready handshakes on both sides.

Parameters:
FIXED_SHIFT, 14, fractional bits of the signed 16-bit fixed-point format (1.0 = 1 << FIXED_SHIFT).
TAG_W, 8, width of the opaque sample tag carried alongside each sample.
SUN_SQUARINGS, 2, number of successive squarings of the sun dot product (1..4; sun power = 2^SUN_SQUARINGS).

Ports:
clk  in  1  sole clock.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  input sample valid.
in_ready  out  1  pipeline can accept a sample this cycle.
in_dir_x, in_dir_y, in_dir_z  in  16 each  signed ray direction, fixed point.
in_tag  in  TAG_W  sample tag.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accepts the output.
out_colour  out  24  {B[23:16], G[15:8], R[7:0]}.
out_tag  out  TAG_W  tag of the output sample.
cfg_wr  in  1  configuration write request.
cfg_ready  out  1  configuration write will be taken this cycle.
cfg_light_x, cfg_light_y, cfg_light_z  in  16 each  signed light direction.
cfg_col_lo  in  24  {B,G,R} colour at ray Y = -1.0.
cfg_col_hi  in  24  {B,G,R} colour at ray Y = +1.0.
cfg_sun_tint  in  24  {B,G,R} sun tint per channel.

Behaviour:
- Reset state:
  - All stage valids and out_valid are 0; out_colour and out_tag are 0.
  - Config registers reset to light (0, ONE, 0), col_lo 0xBE0000, col_hi 0xBEFFFF, sun_tint 0xFFFFFF.
  - Reset mid-operation discards all in-flight samples. No output is produced for them.
- Advance: adv = !out_valid || out_ready. in_ready = adv. The whole pipeline shifts only when adv is 1; every stage holds when adv is 0.
- Accept: a sample is accepted on the edge where in_valid && in_ready.
- Latency: out_valid is high after the (SUN_SQUARINGS+2)th advancing edge, counting the accept edge as the first. Throughput is 1 sample/cycle with no bubbles. Ordering is preserved.
- S1 (dot product):
  - Each product is (a*b) >>> FIXED_SHIFT, 32-bit signed.
  - The three products are summed in 18-bit signed arithmetic, then clamped to [0, ONE].
  - The ray Y component and the tag are carried forward.
- Squaring stages (SUN_SQUARINGS of them): x = (x*x) >> FIXED_SHIFT, unsigned. Because the input is in [0, ONE], x stays ≤ ONE.
- Output stage, per channel c:
  - t = clamp(dirY + ONE, 0, 2*ONE).
  - w = t >> (FIXED_SHIFT-7), range 0..256.
  - grad = lo_c + (((hi_c - lo_c) * w) >>> 8), signed 10-bit intermediate.
  - s = x >> (FIXED_SHIFT-7), range 0..128.
  - sun_c = (s * (tint_c+1)) >> 8.
  - out_c = min(grad + sun_c, 255).
- Config handshake:
  - cfg_ready = 1 only when no stage holds a valid sample and in_valid is 0.
  - cfg_wr && cfg_ready loads all config fields on that edge.
  - cfg_wr while cfg_ready = 0 is ignored; the requester must hold it.
  - A sample accepted on the same edge as a config load is impossible, because cfg_ready requires in_valid = 0.
- Stall: when out_valid is high and out_ready is low, out_colour and out_tag hold stable and no input is taken.

Optional Feature:
Macro SKY_GROUND_EN.
- Defined: any sample with dirY < 0 (sign bit set) outputs cfg_col_lo exactly, with no sun contribution. This is the ground plane.
- Undefined: the gradient and sun apply for all dirY. Latency is the same in both builds.

Decomposition:
- Package SkyPipePkg holds:
  - the FIXED_ONE constant;
  - the rgb24_t typedef (packed b, g, r bytes);
  - the sky_cfg_t struct (light xyz, col_lo, col_hi, sun_tint);
  - reset-default constants;
  - the stage payload struct (valid, dirY, x, tag).
- Sub-module sky_square_stage is a registered fixed-point squaring stage with enable and payload passthrough. It is instantiated SUN_SQUARINGS times via generate.

Test Plan:
1. Default config, dir (0, 0x4000, 0) -> after 4 advancing edges, out_colour 0xFFFFFF. All channels saturate (R: 255+128, B: 190+128).
2. Default config, dir (0x4000, 0, 0) -> 0xBE7F7F. Then dir (0, 0xC000, 0) (-1.0) -> 0xBE0000.
3. Light (0x2D41, 0x2D41, 0), dir (0x4000, 0, 0) -> dot 0x2D41, squares 0x1FFF then 0x0FFF, s = 31 -> 0xDD9E9E.
4. dir (0, 0xE000, 0) (-0.5), default config: macro undefined -> 0xBE3F3F; SKY_GROUND_EN defined -> 0xBE0000.
5. Stream 8 samples with tags 0..7, toggling out_ready 1,0,0,1 repeatedly. Outputs must arrive in tag order with no drops or duplicates, and stay stable while stalled. in_ready must equal adv every cycle.
6. Assert cfg_wr while 3 samples are in flight -> cfg_ready stays 0 until the pipe drains. The write then lands, and the next sample uses the new col_lo. Separately, pulse reset_n low mid-stream -> out_valid drops asynchronously and no stale sample appears after release.

Source files
------------

// File: rtl/sky_shader_pipe_pkg.sv
// Shared types and constants for the pipelined sky shader.
//
// Contents:
//   FIXED_ONE      1.0 in the default signed 16-bit fixed-point format
//   rgb24_t        packed {b, g, r} colour bytes
//   sky_cfg_t      runtime configuration (light direction, gradient endpoints, sun tint)
//   *_RST          reset-time configuration values
//   stage_t        per-stage payload (valid, ray Y, sun term, tag)
//   shade_channel  per-channel gradient + sun blend with saturation

package sky_shader_pipe_pkg;

    localparam int FIXED_SHIFT_DEFAULT = 14;
    localparam int FIXED_ONE           = 1 << FIXED_SHIFT_DEFAULT;

    // Widest tag the payload can carry; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb24_t;

    typedef struct packed {
        logic [15:0] light_x;
        logic [15:0] light_y;
        logic [15:0] light_z;
        rgb24_t      col_lo;
        rgb24_t      col_hi;
        rgb24_t      sun_tint;
    } sky_cfg_t;

    // light_y resets to the instance's own 1.0, so it is built in the top.
    localparam logic [15:0] LIGHT_X_RST  = 16'h0000;
    localparam logic [15:0] LIGHT_Z_RST  = 16'h0000;
    localparam rgb24_t      COL_LO_RST   = 24'hBE0000;
    localparam rgb24_t      COL_HI_RST   = 24'hBEFFFF;
    localparam rgb24_t      SUN_TINT_RST = 24'hFFFFFF;

    typedef struct packed {
        logic                 valid;
        logic [15:0]          dir_y;  // signed ray Y, fixed point
        logic [15:0]          x;      // sun term, 0..1.0
        logic [TAG_MAX_W-1:0] tag;
    } stage_t;

    // lo + ((hi - lo) * w) >>> 8 plus (s * (tint + 1)) >> 8, saturated to 255.
    // w is 0..256, s is 0..128.
    function automatic logic [7:0] shade_channel(
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic [7:0] tint,
        input logic [8:0] w,
        input logic [7:0] s
    );
        logic signed [19:0] diff;
        logic signed [19:0] wide_w;
        logic        [9:0]  grad;
        logic        [8:0]  sun;
        logic        [9:0]  total;
        diff   = 20'(hi) - 20'(lo);
        wide_w = {11'b0, w};
        // Arithmetic shift floors negative deltas; the lerp stays inside 0..255.
        grad   = 10'(lo) + 10'((diff * wide_w) >>> 8);
        sun    = 9'((17'(s) * (17'(tint) + 17'd1)) >> 8);
        total  = grad + 10'(sun);
        return (total > 10'd255) ? 8'hFF : total[7:0];
    endfunction

endpackage

// File: rtl/sky_square_stage.sv
// One registered fixed-point squaring stage of the sun-power chain.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   en            stage advances when high, holds otherwise
//   d             incoming payload; x must lie in 0..1.0
//   q             registered payload with x replaced by (x * x) >> FIXED_SHIFT

module sky_square_stage
    import sky_shader_pipe_pkg::*;
#(
    parameter int FIXED_SHIFT = 14
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   en,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q.valid <= d.valid;
            q.dir_y <= d.dir_y;
            q.tag   <= d.tag;
            // x <= 1.0 keeps the square <= 1.0, so 16 bits never overflow.
            q.x     <= 16'((32'(d.x) * 32'(d.x)) >> FIXED_SHIFT);
        end
    end

endmodule

// File: rtl/sky_shader_pipe.sv
// Pipelined sky-colour shader: ray direction + tag in, saturated {B,G,R} colour + tag out.
//
// Stages: S1 (clamped light dot product), SUN_SQUARINGS squaring stages, output shading.
// Latency is SUN_SQUARINGS + 2 advancing edges; one sample per cycle; order preserved.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   in_valid/in_ready                   input handshake; in_ready = !out_valid || out_ready
//   in_dir_x/y/z, in_tag                signed fixed-point ray direction and opaque tag
//   out_valid/out_ready                 output handshake
//   out_colour, out_tag                 {B,G,R} colour and tag of the output sample
//   cfg_wr/cfg_ready                    config write handshake; ready only when idle
//   cfg_light_x/y/z, cfg_col_lo/hi,     configuration loaded on cfg_wr && cfg_ready
//   cfg_sun_tint
//
// Build option: define SKY_GROUND_EN to output cfg_col_lo unmodified for every ray with
// negative Y (ground plane). Latency is unchanged.

module sky_shader_pipe
    import sky_shader_pipe_pkg::*;
#(
    parameter int FIXED_SHIFT   = 14,
    parameter int TAG_W         = 8,
    parameter int SUN_SQUARINGS = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_dir_x,
    input  logic [15:0]      in_dir_y,
    input  logic [15:0]      in_dir_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_colour,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cfg_wr,
    output logic             cfg_ready,
    input  logic [15:0]      cfg_light_x,
    input  logic [15:0]      cfg_light_y,
    input  logic [15:0]      cfg_light_z,
    input  logic [23:0]      cfg_col_lo,
    input  logic [23:0]      cfg_col_hi,
    input  logic [23:0]      cfg_sun_tint
);

    localparam int ONE = 1 << FIXED_SHIFT;

    logic       adv;
    logic       busy;
    sky_cfg_t   cfg_q;
    sky_cfg_t   cfg_d;
    stage_t     s1_d;
    stage_t     s1_q;
    stage_t     chain [SUN_SQUARINGS+1];

    logic                out_valid_q;
    rgb24_t              out_colour_q;
    logic [TAG_W-1:0]    out_tag_q;

    // Whole pipe moves as one shift register.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // ---------------------------------------------------------------- configuration
    always_comb begin
        busy = out_valid_q;
        for (int i = 0; i <= SUN_SQUARINGS; i++) begin
            busy = busy | chain[i].valid;
        end
    end

    // Only an empty pipe with no sample on offer may be reconfigured, so no sample ever
    // sees a mix of old and new settings.
    assign cfg_ready = !busy && !in_valid;

    always_comb begin
        cfg_d          = cfg_q;
        cfg_d.light_x  = cfg_light_x;
        cfg_d.light_y  = cfg_light_y;
        cfg_d.light_z  = cfg_light_z;
        cfg_d.col_lo   = cfg_col_lo;
        cfg_d.col_hi   = cfg_col_hi;
        cfg_d.sun_tint = cfg_sun_tint;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q.light_x  <= LIGHT_X_RST;
            cfg_q.light_y  <= 16'(ONE);
            cfg_q.light_z  <= LIGHT_Z_RST;
            cfg_q.col_lo   <= COL_LO_RST;
            cfg_q.col_hi   <= COL_HI_RST;
            cfg_q.sun_tint <= SUN_TINT_RST;
        end else if (cfg_wr && cfg_ready) begin
            cfg_q <= cfg_d;
        end
    end

    // ---------------------------------------------------------------- S1: dot product
    logic signed [31:0] ax, ay, az, lx, ly, lz;
    logic        [17:0] dot_sum;

    assign ax = {{16{in_dir_x[15]}}, in_dir_x};
    assign ay = {{16{in_dir_y[15]}}, in_dir_y};
    assign az = {{16{in_dir_z[15]}}, in_dir_z};
    assign lx = {{16{cfg_q.light_x[15]}}, cfg_q.light_x};
    assign ly = {{16{cfg_q.light_y[15]}}, cfg_q.light_y};
    assign lz = {{16{cfg_q.light_z[15]}}, cfg_q.light_z};

    always_comb begin
        // Each product is truncated to 18 bits and the sum wraps in 18 bits.
        dot_sum = 18'((ax * lx) >>> FIXED_SHIFT)
                + 18'((ay * ly) >>> FIXED_SHIFT)
                + 18'((az * lz) >>> FIXED_SHIFT);

        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.dir_y = in_dir_y;
        s1_d.tag   = TAG_MAX_W'(in_tag);
        if (dot_sum[17]) begin
            s1_d.x = '0;
        end else if (dot_sum[16:0] > 17'(ONE)) begin
            s1_d.x = 16'(ONE);
        end else begin
            s1_d.x = dot_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
        end else if (adv) begin
            s1_q <= s1_d;
        end
    end

    // ---------------------------------------------------------------- sun power chain
    assign chain[0] = s1_q;

    for (genvar i = 0; i < SUN_SQUARINGS; i++) begin : g_square
        sky_square_stage #(
            .FIXED_SHIFT(FIXED_SHIFT)
        ) u_square (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (adv),
            .d      (chain[i]),
            .q      (chain[i+1])
        );
    end

    // ---------------------------------------------------------------- output shading
    logic [17:0] t_raw;
    logic [17:0] t;
    logic [8:0]  w;
    logic [7:0]  s;
    rgb24_t      shaded;

    always_comb begin
        t_raw = {{2{chain[SUN_SQUARINGS].dir_y[15]}}, chain[SUN_SQUARINGS].dir_y} + 18'(ONE);
        if (t_raw[17]) begin
            t = '0;
        end else if (t_raw > 18'(2 * ONE)) begin
            t = 18'(2 * ONE);
        end else begin
            t = t_raw;
        end
        w = 9'(t >> (FIXED_SHIFT - 7));
        s = 8'(chain[SUN_SQUARINGS].x >> (FIXED_SHIFT - 7));

        shaded.r = shade_channel(cfg_q.col_lo.r, cfg_q.col_hi.r, cfg_q.sun_tint.r, w, s);
        shaded.g = shade_channel(cfg_q.col_lo.g, cfg_q.col_hi.g, cfg_q.sun_tint.g, w, s);
        shaded.b = shade_channel(cfg_q.col_lo.b, cfg_q.col_hi.b, cfg_q.sun_tint.b, w, s);
`ifdef SKY_GROUND_EN
        if (chain[SUN_SQUARINGS].dir_y[15]) begin
            shaded = cfg_q.col_lo;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_colour_q <= '0;
            out_tag_q    <= '0;
        end else if (adv) begin
            out_valid_q <= chain[SUN_SQUARINGS].valid;
            // Bubbles leave the last colour/tag in place.
            if (chain[SUN_SQUARINGS].valid) begin
                out_colour_q <= shaded;
                out_tag_q    <= chain[SUN_SQUARINGS].tag[TAG_W-1:0];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_colour = out_colour_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_sky_shader_pipe.sv
module tb_sky_shader_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_dir_x, in_dir_y, in_dir_z;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_colour;
    logic [7:0]  out_tag;
    logic        cfg_wr;
    logic        cfg_ready;
    logic [15:0] cfg_light_x, cfg_light_y, cfg_light_z;
    logic [23:0] cfg_col_lo, cfg_col_hi, cfg_sun_tint;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 4;  // SUN_SQUARINGS (2) + 2
`ifdef SKY_GROUND_EN
    localparam logic [23:0] EXP_HALF_DOWN = 24'hBE0000;
`else
    localparam logic [23:0] EXP_HALF_DOWN = 24'hBE3F3F;
`endif

    sky_shader_pipe u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dir_x    (in_dir_x),
        .in_dir_y    (in_dir_y),
        .in_dir_z    (in_dir_z),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_colour  (out_colour),
        .out_tag     (out_tag),
        .cfg_wr      (cfg_wr),
        .cfg_ready   (cfg_ready),
        .cfg_light_x (cfg_light_x),
        .cfg_light_y (cfg_light_y),
        .cfg_light_z (cfg_light_z),
        .cfg_col_lo  (cfg_col_lo),
        .cfg_col_hi  (cfg_col_hi),
        .cfg_sun_tint(cfg_sun_tint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // Stimulus only: one sample through an idle pipe with out_ready held high.
    task automatic run_one(input logic [15:0] dx, input logic [15:0] dy, input logic [15:0] dz,
                           input logic [7:0] tg, output logic [23:0] col,
                           output logic [7:0] otg, output int lat);
        in_dir_x  = dx;
        in_dir_y  = dy;
        in_dir_z  = dz;
        in_tag    = tg;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        col = out_colour;
        otg = out_tag;
        @(posedge clk); #1;
    endtask

    // Stimulus only: config write from an idle pipe; reports cfg_ready seen before the edge.
    task automatic write_cfg(input logic [15:0] lx, input logic [15:0] ly, input logic [15:0] lz,
                             input logic [23:0] lo, input logic [23:0] hi, input logic [23:0] tint,
                             output logic rdy);
        cfg_light_x  = lx;
        cfg_light_y  = ly;
        cfg_light_z  = lz;
        cfg_col_lo   = lo;
        cfg_col_hi   = hi;
        cfg_sun_tint = tint;
        cfg_wr       = 1'b1;
        #1;
        rdy = cfg_ready;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; cfg_wr = 1'b0;
        in_dir_x = '0; in_dir_y = '0; in_dir_z = '0; in_tag = '0;
        cfg_light_x = '0; cfg_light_y = '0; cfg_light_z = '0;
        cfg_col_lo = '0; cfg_col_hi = '0; cfg_sun_tint = '0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (out_colour !== 24'h0 || out_tag !== 8'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h/%h, required 000000/00", out_colour, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got in_ready %b cfg_ready %b, required 1 1",
                     in_ready, cfg_ready);
        end
    endtask

    task automatic test_default_sky();
        logic [23:0] col; logic [7:0] tg; int lat;
        run_one(16'h0000, 16'h4000, 16'h0000, 8'h11, col, tg, lat);
        checks++;
        if (lat !== LAT) begin
            errors++; $display("FAIL latency: got %0d, required %0d", lat, LAT);
        end
        checks++;
        if (col !== 24'hFFFFFF || tg !== 8'h11) begin
            errors++; $display("FAIL zenith_sun: got %h/%h, required FFFFFF/11", col, tg);
        end
        run_one(16'h4000, 16'h0000, 16'h0000, 8'h12, col, tg, lat);
        checks++;
        if (col !== 24'hBE7F7F || tg !== 8'h12) begin
            errors++; $display("FAIL horizon: got %h/%h, required BE7F7F/12", col, tg);
        end
        run_one(16'h0000, 16'hC000, 16'h0000, 8'h13, col, tg, lat);
        checks++;
        if (col !== 24'hBE0000 || tg !== 8'h13) begin
            errors++; $display("FAIL nadir: got %h/%h, required BE0000/13", col, tg);
        end
    endtask

    task automatic test_light_config();
        logic [23:0] col; logic [7:0] tg; int lat; logic rdy;
        write_cfg(16'h2D41, 16'h2D41, 16'h0000, 24'hBE0000, 24'hBEFFFF, 24'hFFFFFF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++; $display("FAIL cfg_ready_idle: got %b, required 1", rdy);
        end
        run_one(16'h4000, 16'h0000, 16'h0000, 8'h21, col, tg, lat);
        checks++;
        if (col !== 24'hDD9E9E || tg !== 8'h21) begin
            errors++; $display("FAIL oblique_sun: got %h/%h, required DD9E9E/21", col, tg);
        end
        write_cfg(16'h0000, 16'h4000, 16'h0000, 24'hBE0000, 24'hBEFFFF, 24'hFFFFFF, rdy);
    endtask

    task automatic test_ground();
        logic [23:0] col; logic [7:0] tg; int lat;
        run_one(16'h0000, 16'hE000, 16'h0000, 8'h31, col, tg, lat);
        checks++;
        if (col !== EXP_HALF_DOWN || tg !== 8'h31) begin
            errors++;
            $display("FAIL half_down: got %h/%h, required %h/31", col, tg, EXP_HALF_DOWN);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pat = 4'b1001;
        int          sent = 0;
        int          got = 0;
        logic        stalled_prev = 1'b0;
        logic [23:0] prev_col = '0;
        logic [7:0]  prev_tag = '0;
        logic        take_in;
        logic        late_valid = 1'b0;
        in_dir_x = 16'h4000; in_dir_y = 16'h0000; in_dir_z = 16'h0000;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            in_tag    = 8'(sent);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready_adv: cycle %0d got %b, required %b", cyc, in_ready,
                         !out_valid || out_ready);
            end
            if (stalled_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_colour !== prev_col || out_tag !== prev_tag) begin
                    errors++;
                    $display("FAIL stall_hold: got %b %h/%h, required 1 %h/%h", out_valid,
                             out_colour, out_tag, prev_col, prev_tag);
                end
            end
            take_in = in_valid && in_ready;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (out_tag !== 8'(got) || out_colour !== 24'hBE7F7F) begin
                    errors++;
                    $display("FAIL stream_order: got %h/%h, required BE7F7F/%h", out_colour,
                             out_tag, 8'(got));
                end
                got++;
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            prev_col = out_colour;
            prev_tag = out_tag;
            @(posedge clk); #1;
            if (take_in) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) late_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (sent !== 8 || got !== 8 || late_valid) begin
            errors++;
            $display("FAIL stream_count: got sent %0d recv %0d extra %b, required 8 8 0",
                     sent, got, late_valid);
        end
    endtask

    task automatic test_cfg_during_flight();
        logic [23:0] col; logic [7:0] tg; int lat;
        int   recv = 0;
        logic exp_rdy;
        logic done = 1'b0;
        out_ready = 1'b1;
        in_dir_x = 16'h0000; in_dir_y = 16'hC000; in_dir_z = 16'h0000;
        in_valid = 1'b1;
        in_tag   = 8'd0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL cfg_ready_in_valid: got %b, required 0", cfg_ready);
        end
        for (int k = 0; k < 3; k++) begin
            in_tag = 8'(k);
            @(posedge clk); #1;
        end
        in_valid     = 1'b0;
        cfg_light_x  = 16'h0000; cfg_light_y = 16'h4000; cfg_light_z = 16'h0000;
        cfg_col_lo   = 24'h123456; cfg_col_hi = 24'hBEFFFF; cfg_sun_tint = 24'hFFFFFF;
        cfg_wr       = 1'b1;
        #1;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            exp_rdy = (recv == 3);
            checks++;
            if (cfg_ready !== exp_rdy) begin
                errors++;
                $display("FAIL cfg_ready_drain: cycle %0d got %b, required %b", cyc, cfg_ready,
                         exp_rdy);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_colour !== 24'hBE0000 || out_tag !== 8'(recv)) begin
                    errors++;
                    $display("FAIL drain_old_cfg: got %h/%h, required BE0000/%h", out_colour,
                             out_tag, 8'(recv));
                end
                recv++;
            end
            if (exp_rdy) done = 1'b1;
            @(posedge clk); #1;
        end
        cfg_wr = 1'b0;
        checks++;
        if (!done) begin
            errors++; $display("FAIL cfg_drain_timeout: got recv %0d, required 3", recv);
        end
        run_one(16'h0000, 16'hC000, 16'h0000, 8'h41, col, tg, lat);
        checks++;
        if (col !== 24'h123456 || tg !== 8'h41) begin
            errors++; $display("FAIL new_col_lo: got %h/%h, required 123456/41", col, tg);
        end
    endtask

    task automatic test_reset_midstream();
        logic [23:0] col; logic [7:0] tg; int lat;
        logic stale = 1'b0;
        out_ready = 1'b1;
        in_dir_x = 16'h0000; in_dir_y = 16'h4000; in_dir_z = 16'h0000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_tag = 8'(8'h50 + k);
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_valid: got %b, required 1", out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_colour !== 24'h0) begin
            errors++;
            $display("FAIL async_reset: got %b %h, required 0 000000", out_valid, out_colour);
        end
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++; $display("FAIL stale_after_reset: got out_valid 1, required 0");
        end
        // col_lo was 123456 before reset; reset must restore BE0000.
        run_one(16'h0000, 16'hC000, 16'h0000, 8'h61, col, tg, lat);
        checks++;
        if (col !== 24'hBE0000 || tg !== 8'h61) begin
            errors++; $display("FAIL cfg_after_reset: got %h/%h, required BE0000/61", col, tg);
        end
    endtask

    initial begin
        test_reset();
        test_default_sky();
        test_light_config();
        test_ground();
        test_back_to_back();
        test_cfg_during_flight();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
